// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 transaction sequencer.
// Holds the FSM encoding, error codes, counter widths and the checksum rule.
package dht11_pkg;

  localparam int FRAME_BITS = 40;
  localparam int US_W       = 15;
  localparam int BIT_W      = 6;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_NORESP = 2'b01;
  localparam logic [1:0] ERR_TMO    = 2'b10;
  localparam logic [1:0] ERR_CSUM   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_REL_WAIT,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_ERR
  } state_e;

  // Frame is b0..b4 MSB first; b4 must equal the 8-bit sum of b0..b3.
  function automatic logic csum_ok(
    input logic [FRAME_BITS-1:0] f
  );
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one-cycle strobe every CLK_PER_US clocks.
// Counts 0..CLK_PER_US-1 and pulses on the wrap value.
module us_tick_gen #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int W = $clog2(CLK_PER_US);
  localparam logic [W-1:0] LAST = W'(CLK_PER_US - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dht11_sequencer.sv
// One DHT11 transaction: host start pulse, sensor response check,
// 40-bit capture and checksum, all timed by a 1 us strobe.
module dht11_sequencer
  import dht11_pkg::*;
#(
  parameter int CLK_PER_US    = 50,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dq_in,
  output logic       dq_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam logic [US_W-1:0] START_CNT = US_W'(START_LOW_US);
  localparam logic [US_W-1:0] TMO_CNT   = US_W'(TIMEOUT_US);
  localparam logic [US_W-1:0] THR_CNT   = US_W'(BIT_THRESH_US);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  state_e state_q, state_d;

  logic tick;
  logic sync1_q, sync2_q, prev_q;
  logic dq_rise, dq_fall, tmo, last_bit, sum_ok;

  logic [US_W-1:0]       us_cnt_q, us_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [1:0]            code_q, code_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           data_q, data_d;

  us_tick_gen #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick_o(tick)
  );

  assign dq_rise  = sync2_q & ~prev_q;
  assign dq_fall  = ~sync2_q & prev_q;
  assign tmo      = us_cnt_q >= TMO_CNT;
  assign last_bit = bit_cnt_q == LAST_BIT;
  assign sum_ok   = csum_ok(frame_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        // the done/err cycle is already IDLE but must not re-arm
        if (start && !done_q && !err_q) state_d = S_START_LOW;
      end
      S_START_LOW: begin
        if (us_cnt_q == START_CNT) state_d = S_REL_WAIT;
      end
      S_REL_WAIT: begin
        if (dq_fall) state_d = S_RESP_LOW;
        else if (tmo) begin
          state_d = S_ERR;
          code_d  = ERR_NORESP;
        end
      end
      S_RESP_LOW: begin
        if (dq_rise) state_d = S_RESP_HIGH;
        else if (tmo) begin
          state_d = S_ERR;
          code_d  = ERR_NORESP;
        end
      end
      S_RESP_HIGH: begin
        if (dq_fall) state_d = S_BIT_LOW;
        else if (tmo) begin
          state_d = S_ERR;
          code_d  = ERR_NORESP;
        end
      end
      S_BIT_LOW: begin
        if (dq_rise) state_d = S_BIT_HIGH;
        else if (tmo) begin
          state_d = S_ERR;
          code_d  = ERR_TMO;
        end
      end
      S_BIT_HIGH: begin
        if (dq_fall) state_d = last_bit ? S_CHECK : S_BIT_LOW;
        else if (tmo) begin
          state_d = S_ERR;
          code_d  = ERR_TMO;
        end
      end
      S_CHECK: begin
        if (sum_ok) state_d = S_IDLE;
        else begin
          state_d = S_ERR;
          code_d  = ERR_CSUM;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dq_oe      = state_q == S_START_LOW;
    busy       = state_q != S_IDLE;
    done_d     = (state_q == S_CHECK) && sum_ok;
    err_d      = state_q == S_ERR;
    err_code_d = err_d ? code_q : err_code_q;
    data_d     = done_d ? frame_q[39:8] : data_q;
  end

  always_comb begin
    us_cnt_d  = us_cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    // a strobe in the transition cycle belongs to the new state
    if (state_d != state_q)
      us_cnt_d = {{(US_W-1){1'b0}}, tick};
    else if (tick && (us_cnt_q != '1))
      us_cnt_d = us_cnt_q + 1'b1;
    if ((state_q == S_IDLE) && (state_d == S_START_LOW))
      bit_cnt_d = '0;
    if ((state_q == S_BIT_HIGH) && dq_fall) begin
      frame_d = {frame_q[FRAME_BITS-2:0], us_cnt_q > THR_CNT};
      if (!last_bit) bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      us_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      code_q     <= ERR_NONE;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      sync1_q    <= dq_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      us_cnt_q   <= us_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      code_q     <= code_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      err_q      <= err_d;
      data_q     <= data_d;
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign hum_int  = data_q[31:24];
  assign hum_dec  = data_q[23:16];
  assign temp_int = data_q[15:8];
  assign temp_dec = data_q[7:0];

endmodule
